// File: rtl/regfile_pkg.sv
// Shared register-file constants and the clear/ready state type.
package regfile_pkg;

  localparam int REG_ZERO = 0;
  localparam int REG_V0   = 2;
  localparam int REG_A0   = 4;
  localparam int REG_SP   = 29;
  localparam int REG_RA   = 31;

  localparam logic [31:0] SP_INIT_DEFAULT = 32'h7fff_fffc;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } rf_state_t;

endpackage

// File: rtl/regfile_multiport_if.sv
// Decode/writeback side bus of the register file: read ports, write ports, debug tap.
interface regfile_multiport_if #(
  parameter int DW     = 32,
  parameter int AW     = 5,
  parameter int NUM_RD = 2
);

  logic                 ready;
  logic [NUM_RD*AW-1:0] rd_addr;
  logic [NUM_RD*DW-1:0] rd_data;
  logic                 we;
  logic [AW-1:0]        wr_addr;
  logic [DW-1:0]        wr_data;
  logic                 link_we;
  logic [DW-1:0]        link_data;
  logic [AW-1:0]        dbg_addr;
  logic [DW-1:0]        dbg_data;

  modport master (
    input  ready, rd_data, dbg_data,
    output rd_addr, we, wr_addr, wr_data, link_we, link_data, dbg_addr
  );

  modport slave (
    output ready, rd_data, dbg_data,
    input  rd_addr, we, wr_addr, wr_data, link_we, link_data, dbg_addr
  );

endinterface

// File: rtl/regfile_init_seq.sv
// Post-reset clear sequencer: walks every register once, loading its architectural
// initial value, then raises ready until the next reset.
module regfile_init_seq
  import regfile_pkg::*;
#(
  parameter int              DW      = 32,
  parameter int              DEPTH   = 32,
  parameter int              AW      = $clog2(DEPTH),
  parameter int              SP_IDX  = REG_SP,
  parameter logic [DW-1:0]   SP_INIT = DW'(SP_INIT_DEFAULT)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          ready,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr,
  output logic [DW-1:0] clr_data
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [AW-1:0] SP_ADDR  = AW'(SP_IDX);

  rf_state_t     state_q, state_d;
  logic [AW-1:0] clr_idx_q, clr_idx_d;
  logic          ready_q, ready_d;

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    ready_d   = ready_q;
    case (state_q)
      CLEAR: begin
        clr_idx_d = clr_idx_q + AW'(1);
        if (clr_idx_q == LAST_IDX) begin
          state_d   = READY;
          ready_d   = 1'b1;
          clr_idx_d = '0;
        end
      end
      READY: begin
        ready_d = 1'b1;
      end
      default: begin
        state_d   = CLEAR;
        clr_idx_d = '0;
        ready_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      ready_q   <= ready_d;
    end
  end

  assign ready    = ready_q;
  assign clr_we   = (state_q == CLEAR);
  assign clr_addr = clr_idx_q;
  assign clr_data = (clr_idx_q == SP_ADDR) ? SP_INIT : '0;

endmodule

// File: rtl/regfile_multiport.sv
// Multi-read-port CPU register file with link port, hardwired zero and sequenced clear.
// Define REGFILE_BYPASS_EN to forward same-edge writes to the read ports.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int            DW       = 32,
  parameter int            DEPTH    = 32,
  parameter int            NUM_RD   = 2,
  parameter int            LINK_IDX = REG_RA,
  parameter int            SP_IDX   = REG_SP,
  parameter logic [DW-1:0] SP_INIT  = DW'(SP_INIT_DEFAULT)
) (
  input logic               clk,
  input logic               rst,
  regfile_multiport_if.slave bus
);

  localparam int            AW        = $clog2(DEPTH);
  localparam logic [AW-1:0] LINK_ADDR = AW'(LINK_IDX);
  localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

  logic          ready;
  logic          clr_we;
  logic [AW-1:0] clr_addr;
  logic [DW-1:0] clr_data;

  logic [DW-1:0] regs_q [DEPTH];

  logic          gen_wr_en;
  logic          link_wr_en;

  regfile_init_seq #(
    .DW      (DW),
    .DEPTH   (DEPTH),
    .AW      (AW),
    .SP_IDX  (SP_IDX),
    .SP_INIT (SP_INIT)
  ) u_init_seq (
    .clk      (clk),
    .rst      (rst),
    .ready    (ready),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .clr_data (clr_data)
  );

  assign bus.ready = ready;

  // Writes are only accepted once the clear walk has finished; index 0 is never written.
  always_comb begin
    gen_wr_en  = ready && bus.we && (bus.wr_addr != ZERO_ADDR);
    link_wr_en = ready && bus.link_we && (LINK_ADDR != ZERO_ADDR);
  end

  // Link write is issued last so it overrides a general write to the same register.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      regs_q[clr_addr] <= clr_data;
    end else begin
      if (gen_wr_en) begin
        regs_q[bus.wr_addr] <= bus.wr_data;
      end
      if (link_wr_en) begin
        regs_q[LINK_ADDR] <= bus.link_data;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [AW-1:0] addr;
      logic [DW-1:0] rd_d;
      logic [DW-1:0] rd_q;

      assign addr = bus.rd_addr[gi*AW +: AW];

      always_comb begin
        rd_d = '0;
        if (ready && (addr != ZERO_ADDR)) begin
`ifdef REGFILE_BYPASS_EN
          if (link_wr_en && (addr == LINK_ADDR)) begin
            rd_d = bus.link_data;
          end else if (gen_wr_en && (addr == bus.wr_addr)) begin
            rd_d = bus.wr_data;
          end else begin
            rd_d = regs_q[addr];
          end
`else
          rd_d = regs_q[addr];
`endif
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          rd_q <= '0;
        end else begin
          rd_q <= rd_d;
        end
      end

      assign bus.rd_data[gi*DW +: DW] = rd_q;
    end
  endgenerate

  assign bus.dbg_data = (bus.dbg_addr == ZERO_ADDR) ? '0 : regs_q[bus.dbg_addr];

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench for regfile_multiport with an array-level reference model checked every cycle.
module tb_regfile_multiport;
  import regfile_pkg::*;

  localparam int DW     = 32;
  localparam int DEPTH  = 32;
  localparam int AW     = 5;
  localparam int NUM_RD = 2;

  logic clk;
  logic rst;

  regfile_multiport_if #(.DW(DW), .AW(AW), .NUM_RD(NUM_RD)) bus ();

  regfile_multiport #(
    .DW(DW), .DEPTH(DEPTH), .NUM_RD(NUM_RD),
    .LINK_IDX(REG_RA), .SP_IDX(REG_SP), .SP_INIT(32'h7fff_fffc)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural register contents plus clear progress.
  logic [DW-1:0]        m_regs  [DEPTH];
  bit                   m_valid [DEPTH];
  logic [NUM_RD*DW-1:0] m_rd;
  bit                   m_on    = 0;
  bit                   m_ready = 0;
  int                   m_clr   = 0;

  always @(posedge clk) begin
    logic [DW-1:0] nxt [DEPTH];
    int a;
    if (rst) begin
      m_on    = 1;
      m_ready = 0;
      m_clr   = 0;
      m_rd    = '0;
    end else if (m_on && !m_ready) begin
      m_regs[m_clr]  = (m_clr == REG_SP) ? 32'h7fff_fffc : 32'h0;
      m_valid[m_clr] = 1;
      m_clr++;
      if (m_clr == DEPTH) m_ready = 1;
      m_rd = '0;
    end else if (m_ready) begin
      nxt = m_regs;
      if (bus.we && bus.wr_addr != 0) nxt[bus.wr_addr] = bus.wr_data;
      if (bus.link_we) nxt[REG_RA] = bus.link_data;
      for (int k = 0; k < NUM_RD; k++) begin
        a = int'(bus.rd_addr[k*AW +: AW]);
`ifdef REGFILE_BYPASS_EN
        m_rd[k*DW +: DW] = (a == 0) ? '0 : nxt[a];
`else
        m_rd[k*DW +: DW] = (a == 0) ? '0 : m_regs[a];
`endif
      end
      m_regs = nxt;
    end
  end

  always @(negedge clk) begin
    int a;
    if (m_on) begin
      check("ready", {63'd0, bus.ready}, {63'd0, m_ready});
      check("rd_data", bus.rd_data, m_rd);
      a = int'(bus.dbg_addr);
      if (a == 0 || m_valid[a])
        check("dbg_data", {32'd0, bus.dbg_data}, {32'd0, ((a == 0) ? 32'h0 : m_regs[a])});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    bus.we = 0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.link_we = 0; bus.link_data = '0;
  endtask

  logic [DW-1:0] exp5;

  initial begin
    rst = 1;
    idle_inputs();
    bus.rd_addr  = '0;
    bus.dbg_addr = '0;
    cyc(); cyc();
    check("reset_ready", {63'd0, bus.ready}, 64'd0);
    check("reset_rd_data", bus.rd_data, 64'd0);
    rst = 0;

    // Clear walk: ready stays low for DEPTH edges
    repeat (31) cyc();
    check("ready_low_31", {63'd0, bus.ready}, 64'd0);
    cyc();
    check("ready_high_32", {63'd0, bus.ready}, 64'd1);
    bus.dbg_addr = 5'd29; #1;
    check("dbg_sp_init", {32'd0, bus.dbg_data}, {32'd0, 32'h7fff_fffc});
    bus.dbg_addr = 5'd5; #1;
    check("dbg_r5_zero", {32'd0, bus.dbg_data}, 64'd0);

    // Write then read back with one cycle latency
    bus.we = 1; bus.wr_addr = 5'd8; bus.wr_data = 32'hDEAD_BEEF;
    cyc();
    idle_inputs();
    bus.rd_addr = {5'd0, 5'd8};
    cyc();
    check("rd0_r8", {32'd0, bus.rd_data[31:0]}, {32'd0, 32'hDEAD_BEEF});

    // Link port beats general port on $ra
    bus.we = 1; bus.wr_addr = 5'd31; bus.wr_data = 32'h1111;
    bus.link_we = 1; bus.link_data = 32'h2222;
    cyc();
    idle_inputs();
    bus.dbg_addr = 5'd31; #1;
    check("dbg_ra_link_wins", {32'd0, bus.dbg_data}, {32'd0, 32'h2222});

    // Writes to $zero are dropped
    bus.we = 1; bus.wr_addr = 5'd0; bus.wr_data = 32'hFFFF_FFFF;
    cyc();
    idle_inputs();
    bus.rd_addr = {5'd0, 5'd0};
    bus.dbg_addr = 5'd0;
    cyc();
    check("rd_zero", bus.rd_data, 64'd0);
    check("dbg_zero", {32'd0, bus.dbg_data}, 64'd0);

    // Same-edge read of register being written
    bus.we = 1; bus.wr_addr = 5'd9; bus.wr_data = 32'hA5A5_A5A5;
    bus.rd_addr = {5'd9, 5'd0};
    cyc();
    idle_inputs();
`ifdef REGFILE_BYPASS_EN
    exp5 = 32'hA5A5_A5A5;
`else
    exp5 = 32'h0;
`endif
    check("rd1_same_edge", {32'd0, bus.rd_data[63:32]}, {32'd0, exp5});
    cyc();
    check("rd1_after", {32'd0, bus.rd_data[63:32]}, {32'd0, 32'hA5A5_A5A5});

    // Argument registers and a same-edge link/read race on $ra
    bus.we = 1; bus.wr_addr = 5'(REG_V0); bus.wr_data = 32'h0000_0042;
    bus.link_we = 1; bus.link_data = 32'h0040_0010;
    bus.rd_addr = {5'd31, 5'(REG_V0)};
    cyc();
    bus.we = 1; bus.wr_addr = 5'(REG_A0); bus.wr_data = 32'h1234_5678;
    bus.link_we = 0;
    bus.rd_addr = {5'(REG_A0), 5'd31};
    cyc();
    idle_inputs();
    check("rd0_ra_after_link", {32'd0, bus.rd_data[31:0]}, {32'd0, 32'h0040_0010});
    bus.dbg_addr = 5'(REG_A0); #1;
    check("dbg_a0", {32'd0, bus.dbg_data}, {32'd0, 32'h1234_5678});
    bus.dbg_addr = 5'(REG_V0); #1;
    check("dbg_v0", {32'd0, bus.dbg_data}, {32'd0, 32'h0000_0042});

    // Reset mid-clear restarts the walk; writes during clear are ignored
    bus.we = 1; bus.wr_addr = 5'd7; bus.wr_data = 32'h1234;
    cyc();
    idle_inputs();
    rst = 1; cyc(); rst = 0;
    repeat (10) cyc();
    rst = 1; cyc(); rst = 0;
    bus.we = 1; bus.wr_addr = 5'd7; bus.wr_data = 32'h5555;
    bus.link_we = 1; bus.link_data = 32'h6666;
    bus.rd_addr = {5'd7, 5'd31};
    repeat (31) cyc();
    check("ready_low_restart", {63'd0, bus.ready}, 64'd0);
    check("rd_held_zero", bus.rd_data, 64'd0);
    cyc();
    idle_inputs();
    check("ready_high_restart", {63'd0, bus.ready}, 64'd1);
    bus.dbg_addr = 5'd7; #1;
    check("dbg_r7_cleared", {32'd0, bus.dbg_data}, 64'd0);
    bus.dbg_addr = 5'd31; #1;
    check("dbg_ra_cleared", {32'd0, bus.dbg_data}, 64'd0);
    bus.dbg_addr = 5'd8; #1;
    check("dbg_r8_cleared", {32'd0, bus.dbg_data}, 64'd0);
    cyc(); cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
